// File: rtl/sigmoid_stream.sv
// Streaming 3-stage score-to-probability converter: hard-sigmoid, PLAN or step per beat,
// with a shared stall (all stages advance together) and a debug count of clipped deliveries.
module sigmoid_stream #(
    parameter int ZW     = 13,
    parameter int W      = 8,
    parameter int FRAC   = 6,
    parameter int SHIFT  = 9,
    parameter int CLIP_X = 4,
    parameter int TAGW   = 4,
    parameter int THRESH = 32,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [ZW-1:0] in_z,
    input  logic [1:0]           in_mode,
    input  logic [TAGW-1:0]      in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_p,
    output logic                 out_dec,
    output logic [TAGW-1:0]      out_tag,
    input  logic                 clr_cnt,
    output logic [CNTW-1:0]      sat_cnt
);
    // DW holds |xq| without overflow; QW has headroom for segment sums and mode-0 shifts.
    localparam int DW = ZW + 1;
    localparam int QW = DW + FRAC + 2;

    localparam logic signed [QW-1:0] ONE   = QW'(1 << FRAC);
    localparam logic signed [QW-1:0] HALF  = QW'(1 << (FRAC - 1));
    localparam logic signed [QW-1:0] K_HI  = QW'((27 << FRAC) >> 5);
    localparam logic signed [QW-1:0] K_MID = QW'((5 << FRAC) >> 3);
    localparam logic signed [QW-1:0] A_SAT = QW'(5 << FRAC);
    localparam logic signed [QW-1:0] A_MID = QW'((19 << FRAC) >> 3);
    localparam logic signed [QW-1:0] THR   = QW'(THRESH);
    localparam logic signed [DW-1:0] CLIPD = DW'(CLIP_X);

    logic [3:1] r_vld;
    logic       w_en;

    assign w_en      = !r_vld[3] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld[3];

    // S1: scaling and abs
    logic signed [ZW-1:0] w_x, w_xq;
    logic signed [DW-1:0] w_xs, w_xe, w_a, w_d1;
    logic [1:0]           w_mode;
    logic                 w_clip1;

    assign w_x  = in_z >>> SHIFT;
    assign w_xq = in_z >>> (SHIFT - FRAC);
    assign w_xs = DW'(w_x);
    assign w_xe = DW'(w_xq);
    assign w_a  = w_xq[ZW-1] ? -w_xe : w_xe;

    always_comb begin
        w_mode  = (in_mode == 2'd3) ? 2'd0 : in_mode;
        w_d1    = w_xs;
        w_clip1 = 1'b0;
        case (w_mode)
            2'd1: begin
                w_d1    = w_a;
                w_clip1 = (QW'(w_a) >= A_SAT);
            end
            2'd2: w_clip1 = 1'b0;
            default: w_clip1 = (w_xs <= -CLIPD) || (w_xs >= CLIPD);
        endcase
    end

    logic [1:0]           r1_mode;
    logic [TAGW-1:0]      r1_tag;
    logic                 r1_clip, r1_neg;
    logic signed [DW-1:0] r1_d;

    // S2: segment evaluation; PLAN yields the positive-side value, mirrored in S3
    logic signed [QW-1:0] w_dq, w_q;
    assign w_dq = QW'(r1_d);

    always_comb begin
        w_q = HALF;
        case (r1_mode)
            2'd1: begin
                if (r1_clip)              w_q = ONE;
                else if (w_dq >= A_MID)   w_q = K_HI + (w_dq >>> 5);
                else if (w_dq >= ONE)     w_q = K_MID + (w_dq >>> 3);
                else                      w_q = HALF + (w_dq >>> 2);
            end
            2'd2: w_q = r1_neg ? '0 : ONE;
            default: begin
                if (r1_clip) w_q = r1_neg ? '0 : ONE;
                else         w_q = HALF + (w_dq <<< (FRAC - 3));
            end
        endcase
    end

    logic [1:0]           r2_mode;
    logic [TAGW-1:0]      r2_tag;
    logic                 r2_clip, r2_neg;
    logic signed [QW-1:0] r2_q;

    // S3: negative mirror, clamp, decision
    logic signed [QW-1:0] w_m, w_p;
    assign w_m = (r2_mode == 2'd1 && r2_neg) ? (ONE - r2_q) : r2_q;
    assign w_p = (w_m < 0) ? '0 : ((w_m > ONE) ? ONE : w_m);

    logic r3_clip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r1_mode <= '0;
            r1_tag  <= '0;
            r1_clip <= 1'b0;
            r1_neg  <= 1'b0;
            r1_d    <= '0;
            r2_mode <= '0;
            r2_tag  <= '0;
            r2_clip <= 1'b0;
            r2_neg  <= 1'b0;
            r2_q    <= '0;
            r3_clip <= 1'b0;
            out_p   <= '0;
            out_dec <= 1'b0;
            out_tag <= '0;
        end else if (w_en) begin
            r_vld   <= {r_vld[2:1], in_valid};
            r1_mode <= w_mode;
            r1_tag  <= in_tag;
            r1_clip <= w_clip1;
            r1_neg  <= in_z[ZW-1];
            r1_d    <= w_d1;
            r2_mode <= r1_mode;
            r2_tag  <= r1_tag;
            r2_clip <= r1_clip;
            r2_neg  <= r1_neg;
            r2_q    <= w_q;
            r3_clip <= r2_clip;
            out_p   <= W'(w_p);
            out_dec <= (w_p >= THR);
            out_tag <= r2_tag;
        end
    end

    // Clear takes priority over a coincident clipped delivery.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            sat_cnt <= '0;
        else if (out_valid && out_ready && r3_clip && (sat_cnt != '1))
            sat_cnt <= sat_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_sigmoid_stream.sv
// Directed bench for sigmoid_stream: scoreboard of expected beats, checked on each output handshake.
module tb_sigmoid_stream;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [12:0] in_z = '0;
    logic [1:0]        in_mode = '0;
    logic [3:0]        in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_p;
    logic              out_dec;
    logic [3:0]        out_tag;
    logic              clr_cnt = 1'b0;
    logic [15:0]       sat_cnt;

    sigmoid_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_dec(out_dec), .out_tag(out_tag),
        .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, st_lo = 1, st_hi = 0;
    int out_cnt = 0, stall_seen = 0;
    bit lat_on = 1'b1;

    typedef struct {
        logic [7:0] p;
        logic [3:0] tag;
        int         c;
        bit         lat;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;
    bit         prev_st = 1'b0;
    logic [7:0] prev_p;
    logic [3:0] prev_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) out_ready = !(cyc >= st_lo && cyc <= st_hi);

    // Sampled after the driver settles; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    e_m = sb.pop_front();
                    chk("p", out_p, e_m.p);
                    chk("dec", out_dec, (e_m.p >= 8'd32));
                    chk("tag", out_tag, e_m.tag);
                    if (e_m.lat) chk("latency", cyc - e_m.c, 3);
                end
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                chk("in_ready_stall", in_ready, 0);
                if (prev_st) begin
                    chk("hold_p", out_p, prev_p);
                    chk("hold_tag", out_tag, prev_tag);
                end
            end
            prev_st  = out_valid && !out_ready;
            prev_p   = out_p;
            prev_tag = out_tag;
        end else begin
            prev_st = 1'b0;
        end
    end

    task automatic send(input int z, input int m, input int tag, input int p);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_z     = 13'(z);
        in_mode  = 2'(m);
        in_tag   = 4'(tag);
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", in_ready, 1);
        sb.push_back('{p: 8'(p), tag: 4'(tag), c: cyc, lat: lat_on});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #3;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_dec", out_dec, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Mode 0 hard-sigmoid, back-to-back
        send(1024, 0, 1, 48);
        send(2047, 0, 2, 56);
        send(-2048, 0, 3, 0);
        send(4095, 0, 4, 64);
        idle();
        drain();
        chk("sat_mode0", sat_cnt, 2);

        @(negedge clk) clr_cnt = 1'b1;
        @(negedge clk) clr_cnt = 1'b0;
        #1;
        chk("sat_clr", sat_cnt, 0);

        // Mode 1 PLAN
        send(0, 1, 1, 32);
        send(512, 1, 2, 48);
        send(-512, 1, 3, 16);
        send(2000, 1, 4, 61);
        send(4095, 1, 5, 64);
        send(-4096, 1, 6, 0);
        idle();
        drain();
        chk("sat_mode1", sat_cnt, 2);

        // Mode 2 step
        send(-1, 2, 7, 0);
        send(0, 2, 8, 64);
        idle();
        drain();
        chk("sat_mode2", sat_cnt, 2);

        // Per-beat mode interleave, z = 1024 (PLAN: xq = 128 -> 40 + 16)
        send(1024, 0, 9, 48);
        send(1024, 1, 10, 56);
        send(1024, 2, 11, 64);
        send(1024, 3, 12, 48);
        idle();
        drain();

        // Backpressure window
        lat_on = 1'b0;
        stall_seen = 0;
        @(negedge clk);
        st_lo = cyc + 4;
        st_hi = cyc + 8;
        send(0, 0, 5, 32);
        send(512, 0, 6, 40);
        send(-512, 0, 7, 24);
        send(1536, 0, 8, 56);
        send(-1024, 0, 9, 16);
        send(-1536, 0, 10, 8);
        idle();
        drain();
        chk("stall_seen", (stall_seen >= 3), 1);
        lat_on = 1'b1;
        chk("sat_bp", sat_cnt, 2);

        // clr_cnt coincident with a clipped delivery
        send(4095, 0, 11, 64);
        base = sb[sb.size()-1].c;
        idle();
        for (int i = 0; i < 20 && cyc != base + 3; i++) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        chk("clr_vs_inc", sat_cnt, 0);
        send(-4096, 0, 12, 0);
        idle();
        drain();
        chk("sat_after_clr", sat_cnt, 1);

        // Reset with beats in flight
        send(1024, 0, 1, 48);
        send(512, 0, 2, 40);
        send(-512, 0, 3, 24);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sat_cnt", sat_cnt, 0);
        chk("midrst_out_p", out_p, 0);
        chk("midrst_out_tag", out_tag, 0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        base = out_cnt;
        repeat (10) @(negedge clk);
        #3;
        chk("no_stale", out_cnt - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
